// File: rtl/adder_tree_frame_packer.sv
// adder_tree_frame_packer: assembles LANES-wide beats into ping-pong frame banks and
// presents each frame, zero-padded past its last written beat, to the adder tree.
module adder_tree_frame_packer #(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 256,
    parameter int LANES  = 8
) (
    input  logic                              i_CLK,
    input  logic                              i_RSTN,
    input  logic                              i_VALID,
    output logic                              o_READY,
    input  logic [LANES*DATA_W-1:0]           i_DATA,
    input  logic                              i_LAST,
    output logic                              o_FRAME_VALID,
    input  logic                              i_FRAME_READY,
    output logic [N_ELEM*DATA_W-1:0]          o_FRAME,
    output logic [$clog2(N_ELEM/LANES):0]     o_FRAME_BEATS
);
    localparam int BEATS   = N_ELEM / LANES;
    localparam int CNT_W   = $clog2(BEATS);
    localparam int LEN_W   = CNT_W + 1;
    localparam int BEAT_W  = LANES * DATA_W;
    localparam int FRAME_W = N_ELEM * DATA_W;

    logic [FRAME_W-1:0] bank_q [2];
    logic [LEN_W-1:0]   len_q [2];
    logic [1:0]         full_q, full_d;
    logic               wr_sel_q, rd_sel_q, run_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, close, rel;
    logic [FRAME_W-1:0] rd_bank;
    logic [LEN_W-1:0]   rd_len;

    assign o_READY = run_q & ~full_q[wr_sel_q];
    assign accept  = i_VALID & o_READY;
    assign close   = accept & (i_LAST | (cnt_q == CNT_W'(BEATS - 1)));
    assign rel     = o_FRAME_VALID & i_FRAME_READY;
    assign cnt_d   = close ? '0 : cnt_q + CNT_W'(accept);

    // setter and clearer can never hit the same bank: close needs it empty, release needs it full
    assign full_d[0] = (full_q[0] | (close & ~wr_sel_q)) & ~(rel & ~rd_sel_q);
    assign full_d[1] = (full_q[1] | (close & wr_sel_q)) & ~(rel & rd_sel_q);

    assign o_FRAME_VALID = full_q[rd_sel_q];
    assign rd_len        = len_q[rd_sel_q];
    assign rd_bank       = bank_q[rd_sel_q];
    assign o_FRAME_BEATS = o_FRAME_VALID ? rd_len : '0;

    for (genvar b = 0; b < BEATS; b++) begin : g_mask
        assign o_FRAME[b*BEAT_W +: BEAT_W] =
            (o_FRAME_VALID && (LEN_W'(b) < rd_len)) ? rd_bank[b*BEAT_W +: BEAT_W] : '0;
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_q ^ close;
            rd_sel_q <= rd_sel_q ^ rel;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
            if (close) len_q[wr_sel_q] <= LEN_W'(cnt_q) + LEN_W'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (accept) bank_q[wr_sel_q][cnt_q*BEAT_W +: BEAT_W] <= i_DATA;
    end
endmodule
